// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared constants for the video interrupt controller: the register map
// seen on the io_* bus and the bit positions used in MASK / STAT / ONESHOT.
// Also provides the helper that turns a compare channel number into the
// address of its low compare byte.
// ---------------------------------------------------------------------------
package video_pkg;

    // Register map (4-bit address space)
    localparam logic [3:0] ADDR_MASK     = 4'd0;
    localparam logic [3:0] ADDR_STAT     = 4'd1;
    localparam logic [3:0] ADDR_ONESHOT  = 4'd2;
    localparam logic [3:0] ADDR_FRAME    = 4'd3;
    localparam logic [3:0] ADDR_VPOS_L   = 4'd4;
    localparam logic [3:0] ADDR_VPOS_H   = 4'd5;
    // Channel i uses CMP_BASE+2i (low byte) and CMP_BASE+2i+1 (high bits)
    localparam logic [3:0] ADDR_CMP_BASE = 4'd6;

    // Bit positions inside MASK / STAT / ONESHOT
    localparam int STAT_BIT_VBLANK = 0;
    localparam int STAT_BIT_LINE0  = 1;   // line channel i sits at LINE0+i

    // Address of the low compare byte for channel ch
    function automatic logic [3:0] cmp_addr_l(input int ch);
        return ADDR_CMP_BASE + 4'(2 * ch);
    endfunction

    // Address of the high compare bits for channel ch
    function automatic logic [3:0] cmp_addr_h(input int ch);
        return ADDR_CMP_BASE + 4'(2 * ch + 1);
    endfunction

endpackage

// File: rtl/video_irqctrl_if.sv
// ---------------------------------------------------------------------------
// video_irqctrl_if
// CPU-side register bus of the video interrupt controller.
//   io_addr    register select
//   io_wrdata  write data
//   io_wren    write strobe, one write per cycle
//   io_rddata  combinational read data for io_addr
// master : the CPU / bus driver
// slave  : the controller
// ---------------------------------------------------------------------------
interface video_irqctrl_if;

    logic [3:0] io_addr;
    logic [7:0] io_wrdata;
    logic       io_wren;
    logic [7:0] io_rddata;

    modport master (
        output io_addr,
        output io_wrdata,
        output io_wren,
        input  io_rddata
    );

    modport slave (
        input  io_addr,
        input  io_wrdata,
        input  io_wren,
        output io_rddata
    );

endinterface

// File: rtl/irq_edge.sv
// ---------------------------------------------------------------------------
// irq_edge
// Rising-edge detector for one interrupt source.
//   clk      clock
//   reset    asynchronous active-high reset
//   level_i  source level (already in the clk domain)
//   pulse_o  high during the cycle in which level_i is 1 but was 0 last cycle
// The history register resets to 1 so a source that is already high when
// reset is released does not produce a spurious event.
// ---------------------------------------------------------------------------
module irq_edge (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic pulse_o
);

    logic hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~hist_q;

endmodule

// File: rtl/video_irqctrl.sv
// ---------------------------------------------------------------------------
// video_irqctrl
// Raster / vertical-blank interrupt controller.
//   clk        clock
//   reset      asynchronous active-high reset
//   bus        register bus (video_irqctrl_if.slave)
//   vpos       current video line, VPOS_W bits, clk domain
//   vblank     vertical blank level, clk domain
//   irq        interrupt request level = OR(STAT & MASK)
//   frame_cnt  8-bit frame counter, counts vblank rising edges
// Parameters:
//   NUM_LINE_IRQ  number of raster-line compare channels (1..4)
//   VPOS_W        width of vpos and of each compare register (8..10)
// ---------------------------------------------------------------------------
module video_irqctrl
    import video_pkg::*;
#(
    parameter int NUM_LINE_IRQ = 2,
    parameter int VPOS_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    video_irqctrl_if.slave    bus,
    input  logic [VPOS_W-1:0] vpos,
    input  logic              vblank,
    output logic              irq,
    output logic [7:0]        frame_cnt
);

    // One status bit for vblank plus one per line channel
    localparam int NB = NUM_LINE_IRQ + 1;

    // Bit 0 of ONESHOT is reserved; only line-channel bits are storable
    localparam logic [NB-1:0] ONESHOT_BITS = {{NUM_LINE_IRQ{1'b1}}, 1'b0};

    logic [NB-1:0]           mask_q, mask_d;
    logic [NB-1:0]           stat_q, stat_d;
    logic [NB-1:0]           oneshot_q, oneshot_d;
    logic [7:0]              frame_q, frame_d;
    logic [NB-1:0]           event_w;
    logic [NUM_LINE_IRQ-1:0] match_w;
    logic [15:0]             cmp_ext_w [NUM_LINE_IRQ];
    logic [15:0]             vpos_ext_w;
    logic [7:0]              rddata_w;

    logic wr_mask, wr_stat, wr_oneshot, wr_frame;

    assign wr_mask    = bus.io_wren && (bus.io_addr == ADDR_MASK);
    assign wr_stat    = bus.io_wren && (bus.io_addr == ADDR_STAT);
    assign wr_oneshot = bus.io_wren && (bus.io_addr == ADDR_ONESHOT);
    assign wr_frame   = bus.io_wren && (bus.io_addr == ADDR_FRAME);

    // Zero-extended view so the high byte reads cleanly for any VPOS_W
    assign vpos_ext_w = 16'(vpos);

    // -----------------------------------------------------------------------
    // Vertical blank edge
    // -----------------------------------------------------------------------
    irq_edge u_edge_vb (
        .clk     (clk),
        .reset   (reset),
        .level_i (vblank),
        .pulse_o (event_w[STAT_BIT_VBLANK])
    );

    // -----------------------------------------------------------------------
    // Line compare channels: compare register, match and edge detector
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINE_IRQ; gi++) begin : g_line
            localparam logic [VPOS_W-1:0] LO_BYTE = VPOS_W'(8'hFF);

            logic [VPOS_W-1:0] cmp_q, cmp_d;
            logic              wr_l, wr_h;

            assign wr_l = bus.io_wren && (bus.io_addr == cmp_addr_l(gi));
            assign wr_h = bus.io_wren && (bus.io_addr == cmp_addr_h(gi));

            // The high write lands on bits [VPOS_W-1:8]; write-data bits
            // above VPOS_W fall off the truncating cast and are ignored.
            always_comb begin
                cmp_d = cmp_q;
                if (wr_l) begin
                    cmp_d = (cmp_q & ~LO_BYTE) | VPOS_W'(bus.io_wrdata);
                end else if (wr_h) begin
                    cmp_d = (cmp_q & LO_BYTE) | VPOS_W'({bus.io_wrdata, 8'h00});
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cmp_q <= '0;
                end else begin
                    cmp_q <= cmp_d;
                end
            end

            assign cmp_ext_w[gi] = 16'(cmp_q);

            // Compare uses the registered value, so a write that creates a
            // match is seen as a rising edge one clock later.
            assign match_w[gi] = (vpos == cmp_q);

            irq_edge u_edge (
                .clk     (clk),
                .reset   (reset),
                .level_i (match_w[gi]),
                .pulse_o (event_w[STAT_BIT_LINE0 + gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control / status registers
    // -----------------------------------------------------------------------
    always_comb begin
        // A MASK write wins over the one-shot self-clear
        if (wr_mask) begin
            mask_d = bus.io_wrdata[NB-1:0];
        end else begin
            mask_d = mask_q & ~(event_w & oneshot_q);
        end

        // Clear first, then set, so a coincident event keeps its bit
        stat_d = stat_q;
        if (wr_stat) begin
            stat_d = stat_d & ~bus.io_wrdata[NB-1:0];
        end
        stat_d = stat_d | event_w;

        oneshot_d = oneshot_q;
        if (wr_oneshot) begin
            oneshot_d = bus.io_wrdata[NB-1:0] & ONESHOT_BITS;
        end

        // A FRAME write forces 0 even when vblank rises in the same cycle
        frame_d = frame_q;
        if (wr_frame) begin
            frame_d = 8'd0;
        end else if (event_w[STAT_BIT_VBLANK]) begin
            frame_d = frame_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q    <= '0;
            stat_q    <= '0;
            oneshot_q <= '0;
            frame_q   <= '0;
        end else begin
            mask_q    <= mask_d;
            stat_q    <= stat_d;
            oneshot_q <= oneshot_d;
            frame_q   <= frame_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux (combinational, no side effects)
    // -----------------------------------------------------------------------
    always_comb begin
        rddata_w = 8'h00;
        case (bus.io_addr)
            ADDR_MASK:    rddata_w = 8'(mask_q);
            ADDR_STAT:    rddata_w = 8'(stat_q);
            ADDR_ONESHOT: rddata_w = 8'(oneshot_q);
            ADDR_FRAME:   rddata_w = frame_q;
            ADDR_VPOS_L:  rddata_w = vpos_ext_w[7:0];
            ADDR_VPOS_H:  rddata_w = vpos_ext_w[15:8];
            default: begin
                // Addresses of absent channels fall through and read 0
                for (int i = 0; i < NUM_LINE_IRQ; i++) begin
                    if (bus.io_addr == cmp_addr_l(i)) begin
                        rddata_w = cmp_ext_w[i][7:0];
                    end
                    if (bus.io_addr == cmp_addr_h(i)) begin
                        rddata_w = cmp_ext_w[i][15:8];
                    end
                end
            end
        endcase
    end

    assign bus.io_rddata = rddata_w;
    assign irq           = |(stat_q & mask_q);
    assign frame_cnt     = frame_q;

endmodule

// File: tb/tb_video_irqctrl.sv
// ---------------------------------------------------------------------------
// tb_video_irqctrl
// Scoreboard bench for video_irqctrl (NUM_LINE_IRQ=2, VPOS_W=10).
// Each stimulus cycle pushes the reference model's expected outputs; a
// monitor on the falling edge pops and compares them. Directed scenarios
// add a few fixed-constant checks on top of the scoreboard.
// ---------------------------------------------------------------------------
module tb_video_irqctrl;

    localparam int NL = 2;
    localparam int VW = 10;
    localparam int NB = NL + 1;

    localparam int A_MASK = 0, A_STAT = 1, A_ONESHOT = 2, A_FRAME = 3;
    localparam int A_VPOSL = 4, A_VPOSH = 5;
    localparam int A_C0L = 6, A_C0H = 7, A_C1L = 8, A_C1H = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [VW-1:0] vpos = '0;
    logic          vblank = 1'b1;
    logic          irq;
    logic [7:0]    frame_cnt;

    video_irqctrl_if bus ();

    video_irqctrl #(
        .NUM_LINE_IRQ (NL),
        .VPOS_W       (VW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .vpos      (vpos),
        .vblank    (vblank),
        .irq       (irq),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    typedef struct {
        int   addr;
        int   rd;
        int   irq;
        int   frame;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endfunction

    // -----------------------------------------------------------------------
    // Reference model: register file as plain integers
    // -----------------------------------------------------------------------
    int m_mask, m_stat, m_oneshot, m_frame;
    int m_cmp [NL];
    bit m_prev_line [NL];   // was line i matching in the previous cycle
    bit m_prev_vb;          // was vblank high in the previous cycle

    function automatic void model_reset();
        m_mask    = 0;
        m_stat    = 0;
        m_oneshot = 0;
        m_frame   = 0;
        for (int i = 0; i < NL; i++) begin
            m_cmp[i]       = 0;
            m_prev_line[i] = 1;
        end
        m_prev_vb = 1;
    endfunction

    function automatic int model_read(int a, int vp);
        if (a == A_MASK)    return m_mask;
        if (a == A_STAT)    return m_stat;
        if (a == A_ONESHOT) return m_oneshot;
        if (a == A_FRAME)   return m_frame;
        if (a == A_VPOSL)   return vp % 256;
        if (a == A_VPOSH)   return vp / 256;
        if (a >= 6 && a < 6 + 2 * NL) begin
            if (a % 2 == 0) return m_cmp[(a - 6) / 2] % 256;
            return m_cmp[(a - 6) / 2] / 256;
        end
        return 0;
    endfunction

    // Advance the model across one clock edge with the given cycle inputs
    function automatic void model_edge(int a, int d, bit we, int vp, bit vb);
        int ev;
        int full;
        full = (1 << NB) - 1;
        ev   = 0;
        for (int i = 0; i < NL; i++) begin
            bit now_match;
            now_match = (vp == m_cmp[i]);
            if (now_match && !m_prev_line[i]) ev |= 1 << (i + 1);
            m_prev_line[i] = now_match;
        end
        if (vb && !m_prev_vb) ev |= 1;
        m_prev_vb = vb;

        if (we && a == A_MASK) m_mask = d & full;
        else                   m_mask = m_mask & ~(ev & m_oneshot);

        if (we && a == A_STAT) m_stat = m_stat & ~d;
        m_stat = m_stat | ev;

        if (we && a == A_ONESHOT) m_oneshot = d & full & ~1;

        if (we && a == A_FRAME) m_frame = 0;
        else if (ev & 1)        m_frame = (m_frame + 1) % 256;

        for (int i = 0; i < NL; i++) begin
            if (we && a == 6 + 2 * i) m_cmp[i] = (m_cmp[i] / 256) * 256 + d;
            if (we && a == 7 + 2 * i) m_cmp[i] = m_cmp[i] % 256 + (d * 256) % (1 << VW);
        end
    endfunction

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic step(input int a, input int d, input bit we, input int vp,
                        input bit vb, input bit rs);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rs;
        bus.io_addr   = 4'(a);
        bus.io_wrdata = 8'(d);
        bus.io_wren   = we;
        vpos          = VW'(vp);
        vblank        = vb;
        if (rs) model_reset();
        e.addr  = a;
        e.rd    = model_read(a, vp);
        e.irq   = ((m_stat & m_mask) != 0) ? 1 : 0;
        e.frame = m_frame;
        sb_q.push_back(e);
        if (!rs) model_edge(a, d, we, vp, vb);
    endtask

    // Move to a point in the current cycle where outputs are stable
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            $display("txn addr=%0d rd=0x%02h irq=%0b frame=%0d", e.addr,
                     bus.io_rddata, irq, frame_cnt);
            check("rddata", int'(bus.io_rddata), e.rd);
            check("irq", int'(irq), e.irq);
            check("frame_cnt", int'(frame_cnt), e.frame);
        end
    end

    // -----------------------------------------------------------------------
    // Directed scenarios followed by random traffic
    // -----------------------------------------------------------------------
    int last_vp = 0;

    initial begin
        bus.io_addr   = '0;
        bus.io_wrdata = '0;
        bus.io_wren   = 1'b0;
        model_reset();

        // Reset held: registers read their reset values
        step(A_STAT,  0, 0, 0, 1, 1);
        step(A_C0L,   0, 0, 0, 1, 1);
        step(A_FRAME, 0, 0, 0, 1, 1);

        // Release with vpos=0=cmp0 and vblank high: no event may fire
        step(A_STAT, 0, 0, 0, 1, 0);
        step(A_STAT, 0, 0, 0, 1, 0);
        settle();
        check("s6_release_stat", int'(bus.io_rddata), 0);
        check("s6_release_frame", int'(frame_cnt), 0);
        step(A_STAT, 0, 0, 5, 0, 0);

        // Line 0 at 100, held, then moving on
        step(A_MASK, 8'h02, 1, 5, 0, 0);
        step(A_C0L,  100,   1, 5, 0, 0);
        step(A_C0H,  0,     1, 5, 0, 0);
        step(A_STAT, 0, 0, 99,  0, 0);
        step(A_STAT, 0, 0, 100, 0, 0);
        step(A_STAT, 0, 0, 100, 0, 0);
        settle();
        check("s1_stat", int'(bus.io_rddata), 8'h02);
        check("s1_irq", int'(irq), 1);
        step(A_STAT, 8'h02, 1, 100, 0, 0);   // clear while still on the line
        step(A_STAT, 0,     0, 100, 0, 0);
        settle();
        check("s1_no_repeat", int'(bus.io_rddata), 0);
        step(A_STAT, 0, 0, 101, 0, 0);

        // Clear and new event on the same edge: set wins
        step(A_STAT, 0, 0, 100, 0, 0);
        step(A_STAT, 0, 0, 101, 0, 0);
        step(A_STAT, 8'h02, 1, 100, 0, 0);
        step(A_STAT, 0,     0, 100, 0, 0);
        settle();
        check("s2_stat", int'(bus.io_rddata), 8'h02);
        check("s2_irq", int'(irq), 1);
        step(A_STAT, 8'hFF, 1, 101, 0, 0);
        step(A_MASK, 8'h00, 1, 101, 0, 0);

        // One-shot on line 1 at 200. The mask clears on the same edge that
        // sets STAT, so irq never rises for this event.
        step(A_ONESHOT, 8'h04, 1, 101, 0, 0);
        step(A_MASK,    8'h04, 1, 101, 0, 0);
        step(A_C1L,     200,   1, 101, 0, 0);
        step(A_C1H,     0,     1, 101, 0, 0);
        step(A_STAT, 0, 0, 199, 0, 0);
        step(A_STAT, 0, 0, 200, 0, 0);
        step(A_STAT, 0, 0, 200, 0, 0);
        settle();
        check("s3_stat_bit2", (int'(bus.io_rddata) >> 2) & 1, 1);
        check("s3_irq", int'(irq), 0);
        step(A_MASK, 0, 0, 200, 0, 0);
        settle();
        check("s3_mask", int'(bus.io_rddata), 0);
        step(A_ONESHOT, 0, 0, 201, 0, 0);
        settle();
        check("s3_oneshot_kept", int'(bus.io_rddata), 8'h04);

        // Frame counter wrap and write/edge collision
        step(A_FRAME, 0, 1, 300, 0, 0);
        for (int k = 0; k < 255; k++) begin
            step(A_FRAME, 0, 0, 300, 1, 0);
            step(A_FRAME, 0, 0, 300, 0, 0);
        end
        settle();
        check("s4_frame_255", int'(frame_cnt), 255);
        step(A_FRAME, 0, 0, 300, 1, 0);
        step(A_FRAME, 0, 0, 300, 0, 0);
        settle();
        check("s4_frame_wrap", int'(frame_cnt), 0);
        step(A_FRAME, 0, 0, 300, 1, 0);
        step(A_FRAME, 0, 0, 300, 0, 0);
        step(A_FRAME, 0, 1, 300, 1, 0);      // write coincident with the edge
        step(A_FRAME, 0, 0, 300, 0, 0);
        settle();
        check("s4_frame_write_wins", int'(frame_cnt), 0);

        // 10-bit compare: 0x1F4 (high write carries junk above bit 1)
        step(A_C0L, 8'hF4, 1, 300, 0, 0);
        step(A_C0H, 8'hFD, 1, 300, 0, 0);
        step(A_C0L, 0, 0, 300, 0, 0);
        settle();
        check("s5_cmp_l", int'(bus.io_rddata), 8'hF4);
        step(A_C0H, 0, 0, 300, 0, 0);
        settle();
        check("s5_cmp_h", int'(bus.io_rddata), 8'h01);
        step(A_STAT, 8'hFF, 1, 300, 0, 0);
        step(A_STAT, 0, 0, 244,  0, 0);      // low byte only
        step(A_STAT, 0, 0, 1012, 0, 0);      // 0x3F4
        step(A_STAT, 0, 0, 300,  0, 0);
        settle();
        check("s5_no_alias", int'(bus.io_rddata), 0);
        step(A_STAT, 0, 0, 500, 0, 0);
        step(A_STAT, 0, 0, 501, 0, 0);
        settle();
        check("s5_event_500", int'(bus.io_rddata), 8'h02);

        // STAT=0x03 with both masked, then reset mid-cycle
        step(A_MASK, 8'h03, 1, 501, 0, 0);
        step(A_STAT, 0, 0, 501, 1, 0);
        step(A_STAT, 0, 0, 501, 1, 0);
        settle();
        check("s6_stat", int'(bus.io_rddata), 8'h03);
        check("s6_irq_before", int'(irq), 1);
        reset = 1'b1;
        #1;
        check("s6_irq_async", int'(irq), 0);
        check("s6_stat_async", int'(bus.io_rddata), 0);
        step(A_MASK,  0, 0, 501, 1, 1);
        step(A_VPOSH, 0, 0, 501, 1, 1);
        step(A_STAT,  0, 0, 501, 1, 0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            int a, d, vp, sel;
            bit we, vb, rs;
            a   = $urandom_range(0, 15);
            d   = $urandom_range(0, 255);
            we  = ($urandom_range(0, 3) == 0);
            vb  = ($urandom_range(0, 3) == 0);
            rs  = ($urandom_range(0, 149) == 0);
            sel = $urandom_range(0, 4);
            case (sel)
                0:       vp = m_cmp[0];
                1:       vp = m_cmp[1];
                2:       vp = last_vp;
                default: vp = $urandom_range(0, (1 << VW) - 1);
            endcase
            last_vp = vp;
            step(a, d, we, vp, vb, rs);
        end

        settle();
        if (sb_q.size() != 0) begin
            check("scoreboard_drained", sb_q.size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "time limit");
    end

endmodule
